// File: rtl/dvs_ravens_pkg.sv
// dvs_ravens_pkg: shared widths, opcodes and spike packet helpers for the DVS-to-RAVENS path
package dvs_ravens_pkg;
  localparam int TIMESTAMP_US_BITS = 32;
  localparam int RAVENS_PKT_BITS = 32;
  localparam int NEURON_ID_BITS = 21;
  localparam logic [2:0] OP_SPIKE = 3'b000;
  localparam logic [2:0] OP_RUN = 3'b001;
  localparam logic [2:0] OP_START = 3'b010;
  typedef struct packed {
    logic [2:0] op;
    logic [NEURON_ID_BITS-1:0] neuron_id;
    logic [7:0] charge;
  } spike_pkt_t;
  typedef enum logic [2:0] {S_EMPTY, S_LOAD, S_READY, S_OFFER, S_JUDGE, S_HOLD} out_state_e;
  function automatic spike_pkt_t make_spike_pkt(input logic [NEURON_ID_BITS-1:0] neuron_id,
                                                input logic [7:0] charge);
    make_spike_pkt = '{op: OP_SPIKE, neuron_id: neuron_id, charge: charge};
  endfunction
endpackage

// File: rtl/dvs_spike_fifo.sv
// dvs_spike_fifo: synchronous FIFO with registered read; pop data appears on rdata_o the cycle after pop_i
module dvs_spike_fifo #(
  parameter int W = 64,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] rdata_q;
  logic [AW:0] wr_q, rd_q;
  logic do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop = pop_i && !empty_o;
  // a pop frees the head slot in the same edge, so a full FIFO can still take a write
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = rdata_q;
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      rdata_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) begin
        rdata_q <= mem_q[rd_q[AW-1:0]];
        rd_q <= rd_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/dvs_ravens_spike_queue.sv
// dvs_ravens_spike_queue: maps DVS events to RAVENS spike packets, queues them and offers them to the transmitter
module dvs_ravens_spike_queue
  import dvs_ravens_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CLKS_PER_US = 50,
  parameter int SENSOR_W = 128,
  parameter int DS_SHIFT = 2,
  parameter logic [7:0] SPIKE_CHARGE = 8'h01
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          evt_valid,
  output logic                          evt_ready,
  input  logic [$clog2(SENSOR_W)-1:0]   evt_x,
  input  logic [$clog2(SENSOR_W)-1:0]   evt_y,
  input  logic                          evt_polarity,
  input  logic [TIMESTAMP_US_BITS-1:0]  evt_timestamp_us,
  output logic [TIMESTAMP_US_BITS-1:0]  time_us,
  output logic                          new_spike,
  output logic [TIMESTAMP_US_BITS-1:0]  ravens_spike_timestamp_us,
  output logic [RAVENS_PKT_BITS-1:0]    ravens_spike,
  input  logic                          rdy_for_next_spike,
  input  logic                          sent_spike,
  output logic [15:0]                   spikes_dropped
);
  localparam int PW = CLKS_PER_US > 1 ? $clog2(CLKS_PER_US) : 1;
  localparam int NW = NEURON_ID_BITS;
  localparam int EW = TIMESTAMP_US_BITS + RAVENS_PKT_BITS;
  logic [PW-1:0] presc_q;
  logic [TIMESTAMP_US_BITS-1:0] time_q;
  logic [15:0] drop_q;
  logic [NW-1:0] row, col, nid;
  logic [EW-1:0] rdata;
  logic wrap, push, pop, advance, drop, fifo_full, fifo_empty;
  out_state_e state_q, state_d;
  assign wrap = presc_q == PW'(CLKS_PER_US - 1);
  assign row = NW'(evt_y >> DS_SHIFT);
  assign col = NW'(evt_x >> DS_SHIFT);
  assign nid = ((row * NW'(SENSOR_W >> DS_SHIFT) + col) << 1) | NW'(evt_polarity);
  assign evt_ready = !fifo_full;
  assign push = evt_valid && evt_ready;
  // the spike in the holding register is released on a reject or a send; EMPTY always looks for work
  assign advance = state_q == S_EMPTY || (state_q == S_JUDGE && rdy_for_next_spike) ||
                   (state_q == S_HOLD && sent_spike);
  assign pop = advance && !fifo_empty;
  assign drop = state_q == S_JUDGE && rdy_for_next_spike;
  dvs_spike_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .wdata_i({evt_timestamp_us, make_spike_pkt(nid, SPIKE_CHARGE)}),
    .rdata_o(rdata),
    .full_o(fifo_full),
    .empty_o(fifo_empty)
  );
  always_comb begin
    state_d = state_q;
    if (advance) state_d = fifo_empty ? S_EMPTY : S_LOAD;
    else
      case (state_q)
        S_LOAD:  state_d = S_READY;
        S_READY: state_d = rdy_for_next_spike ? S_OFFER : S_READY;
        S_OFFER: state_d = S_JUDGE;
        S_JUDGE: state_d = S_HOLD;
        S_HOLD:  state_d = rdy_for_next_spike ? S_OFFER : S_HOLD;
        default: state_d = S_EMPTY;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      presc_q <= '0;
      time_q <= '0;
      drop_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= wrap ? '0 : presc_q + 1'b1;
      time_q <= time_q + TIMESTAMP_US_BITS'(wrap);
      drop_q <= drop_q + 16'(drop && drop_q != 16'hFFFF);
    end
  end
  assign time_us = time_q;
  assign new_spike = state_q == S_OFFER;
  assign ravens_spike = rdata[RAVENS_PKT_BITS-1:0];
  assign ravens_spike_timestamp_us = rdata[EW-1:RAVENS_PKT_BITS];
  assign spikes_dropped = drop_q;
endmodule

// File: tb/tb_dvs_ravens_spike_queue.sv
// tb_dvs_ravens_spike_queue: table-driven vectors plus directed sequences for full, re-offer and mid-operation reset
module tb_dvs_ravens_spike_queue;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, pol = 1'b0, rdy = 1'b0, sent = 1'b0;
  logic [6:0] x = '0, y = '0;
  logic [31:0] ts = '0, time_us, sp_ts, spike;
  logic evt_ready, new_spike;
  logic [15:0] dropped;
  int vectors = 0, miscompares = 0;
  logic ns_prev = 1'b0;
  always #5 clk = ~clk;
  dvs_ravens_spike_queue #(.DEPTH(4), .CLKS_PER_US(4), .SENSOR_W(128), .DS_SHIFT(2),
                           .SPIKE_CHARGE(8'h01)) dut (
    .clk(clk), .rst(rst), .evt_valid(valid), .evt_ready(evt_ready), .evt_x(x), .evt_y(y),
    .evt_polarity(pol), .evt_timestamp_us(ts), .time_us(time_us), .new_spike(new_spike),
    .ravens_spike_timestamp_us(sp_ts), .ravens_spike(spike), .rdy_for_next_spike(rdy),
    .sent_spike(sent), .spikes_dropped(dropped)
  );
  typedef struct {
    logic r, vl;
    logic [6:0] vx, vy;
    logic vp;
    logic [31:0] vts;
    logic vr, vs, e_ns;
    logic [31:0] e_pkt, e_ts;
    logic [15:0] e_drop;
  } vec_t;
  localparam int NV = 27;
  vec_t tbl [NV];
  function automatic vec_t v(input logic r, vl, input logic [6:0] vx, vy, input logic vp,
                             input logic [31:0] vts, input logic vr, vs, en,
                             input logic [31:0] ep, et, input logic [15:0] ed);
    v = '{r: r, vl: vl, vx: vx, vy: vy, vp: vp, vts: vts, vr: vr, vs: vs, e_ns: en,
          e_pkt: ep, e_ts: et, e_drop: ed};
  endfunction
  function automatic logic [31:0] epkt(input int i);
    epkt = (32'(i * 2) << 8) | 32'h1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic push_ev(input int i);
    valid = 1'b1;
    x = 7'(i * 4);
    y = '0;
    pol = 1'b0;
    ts = 32'(1000 + i);
  endtask
  task automatic take(input logic [31:0] pkt, et);
    int n = 0;
    rdy = 1'b1;
    while (!new_spike && n < 20) begin
      tick();
      n++;
    end
    chk("take_offer", new_spike, 1);
    chk("take_pkt", spike, pkt);
    chk("take_ts", sp_ts, et);
    rdy = 1'b0;
    tick();
    tick();
    sent = 1'b1;
    tick();
    sent = 1'b0;
  endtask
  always @(negedge clk) begin
    if (new_spike) begin
      vectors++;
      if (ns_prev) begin
        miscompares++;
        $display("FAIL ns_back_to_back: got 1 expected 0");
      end
    end
    ns_prev = new_spike;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc, n, offers;
    tbl[0]  = v(1, 0,   0,   0, 0,   0, 0, 0, 0, 32'h0,     0,   0);
    tbl[1]  = v(1, 0,   0,   0, 0,   0, 0, 0, 0, 32'h0,     0,   0);
    tbl[2]  = v(0, 1,  10,   4, 1, 100, 1, 0, 0, 32'h0,     0,   0);
    tbl[3]  = v(0, 0,   0,   0, 0,   0, 1, 0, 0, 32'h4501,  100, 0);
    tbl[4]  = v(0, 0,   0,   0, 0,   0, 1, 0, 0, 32'h4501,  100, 0);
    tbl[5]  = v(0, 0,   0,   0, 0,   0, 1, 0, 1, 32'h4501,  100, 0);
    tbl[6]  = v(0, 0,   0,   0, 0,   0, 0, 0, 0, 32'h4501,  100, 0);
    tbl[7]  = v(0, 0,   0,   0, 0,   0, 0, 0, 0, 32'h4501,  100, 0);
    tbl[8]  = v(0, 0,   0,   0, 0,   0, 0, 1, 0, 32'h4501,  100, 0);
    tbl[9]  = v(0, 0,   0,   0, 0,   0, 0, 0, 0, 32'h4501,  100, 0);
    tbl[10] = v(0, 1,   0,   0, 0, 200, 1, 0, 0, 32'h4501,  100, 0);
    tbl[11] = v(0, 1, 127, 127, 1, 300, 1, 0, 0, 32'h1,     200, 0);
    tbl[12] = v(0, 0,   0,   0, 0,   0, 1, 0, 0, 32'h1,     200, 0);
    tbl[13] = v(0, 0,   0,   0, 0,   0, 1, 0, 1, 32'h1,     200, 0);
    tbl[14] = v(0, 0,   0,   0, 0,   0, 1, 0, 0, 32'h1,     200, 0);
    tbl[15] = v(0, 0,   0,   0, 0,   0, 1, 0, 0, 32'h7FF01, 300, 1);
    tbl[16] = v(0, 0,   0,   0, 0,   0, 1, 0, 0, 32'h7FF01, 300, 1);
    tbl[17] = v(0, 0,   0,   0, 0,   0, 1, 0, 1, 32'h7FF01, 300, 1);
    tbl[18] = v(0, 0,   0,   0, 0,   0, 0, 0, 0, 32'h7FF01, 300, 1);
    tbl[19] = v(0, 0,   0,   0, 0,   0, 0, 0, 0, 32'h7FF01, 300, 1);
    tbl[20] = v(0, 0,   0,   0, 0,   0, 0, 0, 0, 32'h7FF01, 300, 1);
    tbl[21] = v(0, 0,   0,   0, 0,   0, 0, 0, 0, 32'h7FF01, 300, 1);
    tbl[22] = v(0, 0,   0,   0, 0,   0, 1, 0, 1, 32'h7FF01, 300, 1);
    tbl[23] = v(0, 0,   0,   0, 0,   0, 0, 0, 0, 32'h7FF01, 300, 1);
    tbl[24] = v(0, 0,   0,   0, 0,   0, 0, 0, 0, 32'h7FF01, 300, 1);
    tbl[25] = v(0, 0,   0,   0, 0,   0, 0, 1, 0, 32'h7FF01, 300, 1);
    tbl[26] = v(0, 0,   0,   0, 0,   0, 1, 0, 0, 32'h7FF01, 300, 1);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("time_reset", time_us, 0);
    repeat (4) tick();
    chk("time_4clk", time_us, 1);
    repeat (4) tick();
    chk("time_8clk", time_us, 2);
    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].r; valid = tbl[i].vl; x = tbl[i].vx; y = tbl[i].vy; pol = tbl[i].vp;
      ts = tbl[i].vts; rdy = tbl[i].vr; sent = tbl[i].vs;
      tick();
      chk($sformatf("row%0d_new_spike", i), new_spike, tbl[i].e_ns);
      chk($sformatf("row%0d_evt_ready", i), evt_ready, 1);
      chk($sformatf("row%0d_pkt", i), spike, tbl[i].e_pkt);
      chk($sformatf("row%0d_ts", i), sp_ts, tbl[i].e_ts);
      chk($sformatf("row%0d_dropped", i), dropped, tbl[i].e_drop);
    end
    valid = 1'b0; rdy = 1'b0; sent = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      push_ev(i);
      chk($sformatf("full_ready%0d", i), evt_ready, 32'(i < 5));
      if (evt_ready) acc++;
      tick();
    end
    valid = 1'b0;
    chk("full_accepted", acc, 5);
    chk("full_hold_pkt", spike, epkt(0));
    chk("full_hold_ts", sp_ts, 1000);
    rdy = 1'b1;
    tick();
    chk("full_offer", new_spike, 1);
    tick();
    chk("full_still_full", evt_ready, 0);
    tick();
    chk("full_rej_pkt", spike, epkt(1));
    chk("full_rej_ts", sp_ts, 1001);
    chk("full_rej_drop", dropped, 1);
    chk("full_rej_ready", evt_ready, 1);
    repeat (3) tick();
    push_ev(5);
    chk("pp_ready", evt_ready, 1);
    tick();
    valid = 1'b0;
    chk("pp_pkt", spike, epkt(2));
    chk("pp_drop", dropped, 2);
    chk("pp_ready_after", evt_ready, 1);
    rdy = 1'b0;
    push_ev(6);
    tick();
    valid = 1'b0;
    chk("refill_full", evt_ready, 0);
    for (int i = 2; i <= 6; i++) take(epkt(i), 32'(1000 + i));
    chk("drain_ready", evt_ready, 1);
    chk("drain_drop", dropped, 2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_ev(i);
      tick();
    end
    valid = 1'b0;
    rdy = 1'b1;
    n = 0;
    while (!new_spike && n < 20) begin
      tick();
      n++;
    end
    chk("mr_offer", new_spike, 1);
    rdy = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_new_spike", new_spike, 0);
    chk("mr_ready", evt_ready, 1);
    chk("mr_pkt", spike, 0);
    chk("mr_drop", dropped, 0);
    rdy = 1'b1;
    offers = 0;
    repeat (20) begin
      tick();
      if (new_spike) offers++;
    end
    chk("mr_no_offer", offers, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
